// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits (LSB first), parity bit, stop bit.
// Presents the data word with a parity-match flag, a stop-bit error flag and a one-cycle valid pulse.
module parity_frame_rx #(
   parameter int unsigned DATA_W     = 3,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_en,
   input  logic              rx_in,
   output logic [DATA_W-1:0] data_out,
   output logic              par_ok,
   output logic              frame_err,
   output logic              out_valid,
   output logic              busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

   logic [1:0]        r_state;
   logic [CntW-1:0]   r_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_pbit;
   logic [DATA_W-1:0] r_data;
   logic              r_par_ok;
   logic              r_frame_err;
   logic              r_out_valid;

   logic [1:0]        w_state_d;
   logic [CntW-1:0]   w_cnt_d;
   logic [DATA_W-1:0] w_shift_d;
   logic              w_pbit_d;
   logic              w_stop_edge;
   logic              w_par_calc;

   assign w_par_calc = (^r_shift) ^ PARITY_ODD;

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_shift_d   = r_shift;
      w_pbit_d    = r_pbit;
      w_stop_edge = 1'b0;
      if (bit_en) begin
         unique case (r_state)
            IDLE: begin
               // Any low sample starts a frame; there is no mid-bit re-check.
               if (!rx_in) begin
                  w_state_d = DATA;
                  w_cnt_d   = '0;
               end
            end
            DATA: begin
               w_shift_d[r_cnt] = rx_in;
               if (r_cnt == LastCnt) begin
                  w_state_d = PARITY;
               end else begin
                  w_cnt_d = r_cnt + 1'b1;
               end
            end
            PARITY: begin
               w_pbit_d  = rx_in;
               w_state_d = STOP;
            end
            STOP: begin
               w_stop_edge = 1'b1;
               w_state_d   = IDLE;
            end
            default: w_state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_pbit  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_shift <= w_shift_d;
         r_pbit  <= w_pbit_d;
      end
   end

   // Result registers; out_valid drops on the following edge even when bit_en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data      <= '0;
         r_par_ok    <= 1'b0;
         r_frame_err <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= w_stop_edge;
         if (w_stop_edge) begin
            r_data      <= r_shift;
            r_par_ok    <= (r_pbit == w_par_calc);
            r_frame_err <= ~rx_in;
         end
      end
   end

   assign data_out  = r_data;
   assign par_ok    = r_par_ok;
   assign frame_err = r_frame_err;
   assign out_valid = r_out_valid;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: an even-parity and an odd-parity instance share one serial line
// and are checked against a frame-level model of the protocol.
module tb_parity_frame_rx;

   localparam int unsigned DW = 3;

   logic          clk;
   logic          rst_n;
   logic          bit_en;
   logic          rx_in;
   logic [DW-1:0] e_data, o_data;
   logic          e_ok, o_ok, e_ferr, o_ferr, e_vld, o_vld, e_busy, o_busy;

   int vectors;
   int miscompares;
   int exp_pulses;
   int pulses_e, pulses_o;
   logic prev_e, prev_o;

   parity_frame_rx #(.DATA_W(DW), .PARITY_ODD(1'b0)) dut_e (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
      .data_out(e_data), .par_ok(e_ok), .frame_err(e_ferr), .out_valid(e_vld), .busy(e_busy)
   );

   parity_frame_rx #(.DATA_W(DW), .PARITY_ODD(1'b1)) dut_o (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
      .data_out(o_data), .par_ok(o_ok), .frame_err(o_ferr), .out_valid(o_vld), .busy(o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counting and width check, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_e = 1'b0;
         prev_o = 1'b0;
      end else begin
         if (e_vld) begin
            pulses_e++;
            vectors++;
            if (prev_e !== 1'b0) begin
               miscompares++;
               $display("FAIL even_valid_width: out_valid high %0d cycles in a row, required 1", 2);
            end
         end
         if (o_vld) begin
            pulses_o++;
            vectors++;
            if (prev_o !== 1'b0) begin
               miscompares++;
               $display("FAIL odd_valid_width: out_valid high %0d cycles in a row, required 1", 2);
            end
         end
         prev_e = e_vld;
         prev_o = o_vld;
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bit_en = 1'b1;
         rx_in  = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   // stall_mode: 0 none, 1 two bit_en=0 cycles between bits, 2 random 0..2 stall cycles.
   task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop,
                             input int stall_mode);
      logic bits[$];
      int   nst;
      logic exp_ok_e, exp_ok_o;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      bits.push_back(pbit);
      bits.push_back(stop);
      // Even: parity bit equals 1 when the data has an odd number of ones; odd parity inverts.
      exp_ok_e = (pbit == (($countones(d) % 2) == 1));
      exp_ok_o = (pbit == (($countones(d) % 2) == 0));
      for (int idx = 0; idx < bits.size(); idx++) begin
         nst = 0;
         if (idx > 0 && stall_mode == 1) nst = 2;
         if (idx > 0 && stall_mode == 2) nst = $urandom_range(0, 2);
         for (int s = 0; s < nst; s++) begin
            bit_en = 1'b0;
            rx_in  = 1'($urandom);
            @(posedge clk);
            #1;
         end
         bit_en = 1'b1;
         rx_in  = bits[idx];
         @(posedge clk);
         #1;
         if (idx < bits.size() - 1) begin
            vectors++;
            if (e_busy !== 1'b1 || o_busy !== 1'b1) begin
               miscompares++;
               $display("FAIL busy_in_frame: got e=%b o=%b, required 1", e_busy, o_busy);
            end
            vectors++;
            if (e_vld !== 1'b0 || o_vld !== 1'b0) begin
               miscompares++;
               $display("FAIL valid_in_frame: got e=%b o=%b, required 0", e_vld, o_vld);
            end
         end
      end
      exp_pulses++;
      vectors++;
      if (e_vld !== 1'b1 || e_data !== d || e_ok !== exp_ok_e || e_ferr !== ~stop
          || e_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL even_result: got v=%b d=%b ok=%b ferr=%b busy=%b, required v=1 d=%b ok=%b ferr=%b busy=0",
                  e_vld, e_data, e_ok, e_ferr, e_busy, d, exp_ok_e, ~stop);
      end
      vectors++;
      if (o_vld !== 1'b1 || o_data !== d || o_ok !== exp_ok_o || o_ferr !== ~stop
          || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL odd_result: got v=%b d=%b ok=%b ferr=%b busy=%b, required v=1 d=%b ok=%b ferr=%b busy=0",
                  o_vld, o_data, o_ok, o_ferr, o_busy, d, exp_ok_o, ~stop);
      end
      rx_in = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      bit_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rx_in = i[0];
         @(posedge clk);
         #1;
         vectors++;
         if ({e_data, e_ok, e_ferr, e_vld, e_busy, o_data, o_ok, o_ferr, o_vld, o_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: got e=%b/%b/%b/%b/%b o=%b/%b/%b/%b/%b, required all 0",
                     e_data, e_ok, e_ferr, e_vld, e_busy, o_data, o_ok, o_ferr, o_vld, o_busy);
         end
      end
      rx_in = 1'b1;
      rst_n = 1'b1;
      idle(3);
      vectors++;
      if ({e_data, e_ok, e_ferr, e_vld, e_busy, o_data, o_ok, o_ferr, o_vld, o_busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_release: got e=%b/%b/%b/%b/%b, required all 0",
                  e_data, e_ok, e_ferr, e_vld, e_busy);
      end
   endtask

   task automatic test_sweep();
      for (int w = 0; w < 8; w++) begin
         logic [DW-1:0] d;
         d = DW'(w);
         send_frame(d, (($countones(d) % 2) == 1), 1'b1, 0);
         idle(1);
      end
   endtask

   task automatic test_parity_error();
      send_frame(3'b101, 1'b1, 1'b1, 0);
      idle(2);
   endtask

   task automatic test_stop_error();
      send_frame(3'b011, 1'b0, 1'b0, 0);
      idle(3);
      send_frame(3'b110, 1'b0, 1'b1, 0);
      idle(1);
   endtask

   task automatic test_back_to_back();
      send_frame(3'b001, 1'b1, 1'b1, 1);
      send_frame(3'b110, 1'b0, 1'b1, 1);
      idle(2);
   endtask

   task automatic test_midframe_reset();
      int base_e, base_o;
      base_e = pulses_e;
      base_o = pulses_o;
      bit_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx_in = (i == 0) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({e_data, e_ok, e_ferr, e_vld, e_busy, o_data, o_ok, o_ferr, o_vld, o_busy} !== '0) begin
         miscompares++;
         $display("FAIL midframe_reset: got e=%b/%b/%b/%b/%b, required all 0",
                  e_data, e_ok, e_ferr, e_vld, e_busy);
      end
      rx_in = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(4);
      vectors++;
      if (pulses_e != base_e || pulses_o != base_o) begin
         miscompares++;
         $display("FAIL midframe_no_valid: got %0d/%0d extra pulses, required 0",
                  pulses_e - base_e, pulses_o - base_o);
      end
      send_frame(3'b010, 1'b1, 1'b1, 0);
      idle(1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         logic [DW-1:0] d;
         logic          pb;
         d  = DW'($urandom_range(0, 7));
         pb = (($countones(d) % 2) == 1) ^ ($urandom_range(0, 3) == 0);
         send_frame(d, pb, ($urandom_range(0, 4) != 0), 2);
         idle($urandom_range(0, 2));
      end
      idle(2);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_pulses  = 0;
      pulses_e    = 0;
      pulses_o    = 0;
      prev_e      = 1'b0;
      prev_o      = 1'b0;
      rst_n       = 1'b0;
      bit_en      = 1'b0;
      rx_in       = 1'b1;
      test_reset();
      test_sweep();
      test_parity_error();
      test_stop_error();
      test_back_to_back();
      test_midframe_reset();
      test_random();
      @(negedge clk);
      vectors++;
      if (pulses_e != exp_pulses || pulses_o != exp_pulses) begin
         miscompares++;
         $display("FAIL pulse_count: got e=%0d o=%0d, required %0d", pulses_e, pulses_o, exp_pulses);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
